// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the 8-bit bus CPU control path: opcodes,
// control-word bit positions and a helper for building control words.
package control_sequencer_pkg;

    localparam int CTRL_WIDTH = 16;

    // Opcodes (upper nibble of the instruction register).
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit indices, reused when wiring register enable/load pins.
    localparam int CTRL_HLT = 15;
    localparam int CTRL_MI  = 14;
    localparam int CTRL_RI  = 13;
    localparam int CTRL_RO  = 12;
    localparam int CTRL_IO  = 11;
    localparam int CTRL_II  = 10;
    localparam int CTRL_AI  = 9;
    localparam int CTRL_AO  = 8;
    localparam int CTRL_EO  = 7;
    localparam int CTRL_SU  = 6;
    localparam int CTRL_BI  = 5;
    localparam int CTRL_OI  = 4;
    localparam int CTRL_CE  = 3;
    localparam int CTRL_CO  = 2;
    localparam int CTRL_J   = 1;
    localparam int CTRL_FI  = 0;

    typedef logic [CTRL_WIDTH-1:0] ctrl_t;

    // One-hot control word with only the given bit set.
    function automatic ctrl_t cbit(input int idx);
        return ctrl_t'(1) << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Microcode ROM: pure combinational lookup from {opcode, step, carry, zero}
// to the 16-bit control word plus the end-of-instruction marker rsc.
module microcode_rom
    import control_sequencer_pkg::*;
#(
    parameter int STEP_WIDTH = 3
) (
    input  logic [3:0]            opcode,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  carry,
    input  logic                  zero,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  rsc
);

    // Decode one microinstruction; fetch steps are shared by all opcodes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        ctrl = '0;
        rsc  = 1'b0;
        case (step)
            STEP_WIDTH'(0): ctrl = cbit(CTRL_CO) | cbit(CTRL_MI);
            STEP_WIDTH'(1): ctrl = cbit(CTRL_RO) | cbit(CTRL_II) | cbit(CTRL_CE);
            STEP_WIDTH'(2): begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = cbit(CTRL_IO) | cbit(CTRL_MI);
                    OP_LDI: begin
                        ctrl = cbit(CTRL_IO) | cbit(CTRL_AI);
                        rsc  = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl = cbit(CTRL_IO) | cbit(CTRL_J);
                        rsc  = 1'b1;
                    end
                    OP_JC: begin
                        if (carry) ctrl = cbit(CTRL_IO) | cbit(CTRL_J);
                        rsc = 1'b1;
                    end
                    OP_JZ: begin
                        if (zero) ctrl = cbit(CTRL_IO) | cbit(CTRL_J);
                        rsc = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl = cbit(CTRL_AO) | cbit(CTRL_OI);
                        rsc  = 1'b1;
                    end
                    OP_HLT: ctrl = cbit(CTRL_HLT);
                    // NOP and the undefined opcodes end here with no strobes.
                    default: rsc = 1'b1;
                endcase
            end
            STEP_WIDTH'(3): begin
                case (opcode)
                    OP_LDA: begin
                        ctrl = cbit(CTRL_RO) | cbit(CTRL_AI);
                        rsc  = 1'b1;
                    end
                    OP_ADD, OP_SUB:
                        ctrl = cbit(CTRL_RO) | cbit(CTRL_BI);
                    OP_STA: begin
                        ctrl = cbit(CTRL_AO) | cbit(CTRL_RI);
                        rsc  = 1'b1;
                    end
                    default: ;
                endcase
            end
            STEP_WIDTH'(4): begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl = cbit(CTRL_EO) | cbit(CTRL_AI) | cbit(CTRL_FI);
                    if (opcode == OP_SUB) ctrl = ctrl | cbit(CTRL_SU);
                    rsc = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: T-state step counter, halt latch and reset gating
// around the microcode ROM. The control word is combinational in the
// current step so registers see it at the next rising clk.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int STEP_WIDTH = 3,
    parameter int MAX_STEP   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            opcode,
    input  logic                  carry_flag,
    input  logic                  zero_flag,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  halted
);

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(MAX_STEP - 1);

    logic [CTRL_WIDTH-1:0] rom_ctrl;
    logic                  rsc;

    microcode_rom #(
        .STEP_WIDTH(STEP_WIDTH)
    ) u_rom (
        .opcode(opcode),
        .step  (step),
        .carry (carry_flag),
        .zero  (zero_flag),
        .ctrl  (rom_ctrl),
        .rsc   (rsc)
    );

    // No register may load or drive during reset or after a halt.
    assign ctrl = (rst || halted) ? '0 : rom_ctrl;

    // Step counter and halt latch: halt freezes the step, rsc or the last
    // legal step returns to fetch T0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            step   <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (ctrl[CTRL_HLT]) begin
                halted <= 1'b1;
            end else if (rsc || step == LAST_STEP) begin
                step <= '0;
            end else begin
                step <= step + STEP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction sequences followed by
// random opcode/flag/reset traffic, checked against an instruction-level
// reference model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int m_step     = 0;
    bit m_halted   = 1'b0;
    bit force_wrap = 1'b0;

    always #5 clk = ~clk;

    control_sequencer #(
        .STEP_WIDTH(3),
        .MAX_STEP  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .carry_flag(carry_flag),
        .zero_flag (zero_flag),
        .ctrl      (ctrl),
        .step      (step),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-instruction control-word sequences, written out as listed for
    // each opcode; 'last' marks the final step of the instruction.
    task automatic model_lookup(input logic [3:0] op, input bit c, input bit z, input int idx,
                                output logic [15:0] word, output bit last);
        logic [15:0] s [5];
        int n;
        s = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000};
        n = 3;
        case (op)
            4'h1: begin s[2] = 16'h4800; s[3] = 16'h1200; n = 4; end
            4'h2: begin s[2] = 16'h4800; s[3] = 16'h1020; s[4] = 16'h0281; n = 5; end
            4'h3: begin s[2] = 16'h4800; s[3] = 16'h1020; s[4] = 16'h02C1; n = 5; end
            4'h4: begin s[2] = 16'h4800; s[3] = 16'h2100; n = 4; end
            4'h5: s[2] = 16'h0A00;
            4'h6: s[2] = 16'h0802;
            4'h7: s[2] = c ? 16'h0802 : 16'h0000;
            4'h8: s[2] = z ? 16'h0802 : 16'h0000;
            4'hE: s[2] = 16'h0110;
            4'hF: s[2] = 16'h8000;
            default: ;
        endcase
        word = (idx >= 0 && idx < 5) ? s[idx] : 16'h0000;
        last = (idx == n - 1);
    endtask

    // One clock cycle: apply inputs, compare before the edge, advance model.
    // want < 0 means no extra directed expectation on ctrl.
    task automatic cycle(input bit r, input logic [3:0] op, input bit c, input bit z, input int want);
        logic [15:0] w;
        logic [15:0] exp_ctrl;
        bit          last;
        int          bus;
        rst        = r;
        opcode     = op;
        carry_flag = c;
        zero_flag  = z;
        @(negedge clk);
        model_lookup(op, c, z, m_step, w, last);
        exp_ctrl = (r || m_halted) ? 16'h0000 : w;
        check("ctrl", 32'(ctrl), 32'(exp_ctrl));
        check("step", 32'(step), m_step);
        check("halted", 32'(halted), 32'(m_halted));
        if (want >= 0) check("ctrl_directed", 32'(ctrl), want);
        bus = int'(ctrl[12]) + int'(ctrl[11]) + int'(ctrl[8]) + int'(ctrl[7]) + int'(ctrl[2]);
        check("bus_exclusive", 32'(bus <= 1), 1);
        check("su_needs_eo", 32'(ctrl[6] & ~ctrl[7]), 0);
        check("j_needs_io", 32'(ctrl[1] & ~ctrl[11]), 0);
        @(posedge clk);
        if (r) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (exp_ctrl[15]) m_halted = 1'b1;
            else if ((last && !force_wrap) || m_step == 4) m_step = 0;
            else m_step++;
        end
        #1;
    endtask

    initial begin
        logic [3:0] op;
        rst        = 1'b1;
        opcode     = 4'h0;
        carry_flag = 1'b0;
        zero_flag  = 1'b0;
        @(posedge clk);
        #1;

        // Reset state.
        cycle(1, 4'h0, 0, 0, 'h0000);

        // Reset in the middle of ADD, then a full ADD.
        cycle(0, 4'h2, 0, 0, 'h4004);
        cycle(0, 4'h2, 0, 0, 'h1408);
        cycle(0, 4'h2, 0, 0, 'h4800);
        cycle(0, 4'h2, 0, 0, 'h1020);
        cycle(1, 4'h2, 0, 0, 'h0000);
        cycle(0, 4'h2, 0, 0, 'h4004);
        cycle(0, 4'h2, 0, 0, 'h1408);
        cycle(0, 4'h2, 0, 0, 'h4800);
        cycle(0, 4'h2, 0, 0, 'h1020);
        cycle(0, 4'h2, 1, 0, 'h0281);

        // LDA: four steps, then back to fetch.
        cycle(0, 4'h1, 0, 0, 'h4004);
        cycle(0, 4'h1, 0, 0, 'h1408);
        cycle(0, 4'h1, 0, 0, 'h4800);
        cycle(0, 4'h1, 0, 0, 'h1200);

        // SUB: su joins eo in the last step.
        cycle(0, 4'h3, 0, 0, 'h4004);
        cycle(0, 4'h3, 0, 0, 'h1408);
        cycle(0, 4'h3, 0, 0, 'h4800);
        cycle(0, 4'h3, 0, 0, 'h1020);
        cycle(0, 4'h3, 0, 0, 'h02C1);

        // JC taken, then not taken.
        cycle(0, 4'h7, 1, 0, 'h4004);
        cycle(0, 4'h7, 1, 0, 'h1408);
        cycle(0, 4'h7, 1, 0, 'h0802);
        cycle(0, 4'h7, 0, 1, 'h4004);
        cycle(0, 4'h7, 0, 1, 'h1408);
        cycle(0, 4'h7, 0, 1, 'h0000);
        // JZ with the flag changing inside T2.
        cycle(0, 4'h8, 0, 0, 'h4004);
        cycle(0, 4'h8, 0, 0, 'h1408);
        cycle(0, 4'h8, 0, 1, 'h0802);

        // HLT: halts, stays frozen, only reset recovers.
        cycle(0, 4'hF, 0, 0, 'h4004);
        cycle(0, 4'hF, 0, 0, 'h1408);
        cycle(0, 4'hF, 0, 0, 'h8000);
        for (int i = 0; i < 10; i++) cycle(0, 4'(i), i[0], i[1], 'h0000);
        cycle(1, 4'hF, 0, 0, 'h0000);
        cycle(0, 4'h0, 0, 0, 'h4004);

        // Sweep every opcode and flag combination from reset.
        for (int o = 0; o < 16; o++) begin
            for (int f = 0; f < 4; f++) begin
                cycle(1, 4'(o), f[0], f[1], 'h0000);
                for (int k = 0; k < 6; k++) cycle(0, 4'(o), f[0], f[1], -1);
            end
        end

        // Wrap path: with the end-of-instruction marker held low the
        // counter must still return to 0 after step 4.
        cycle(1, 4'h0, 0, 0, 'h0000);
        force dut.rsc = 1'b0;
        force_wrap = 1'b1;
        for (int k = 0; k < 7; k++) cycle(0, 4'h0, 0, 0, -1);
        for (int k = 0; k < 6; k++) cycle(0, 4'h1, 0, 0, -1);
        release dut.rsc;
        force_wrap = 1'b0;
        cycle(1, 4'h0, 0, 0, 'h0000);

        // Random traffic: opcode mostly held for a whole instruction.
        op = 4'h0;
        for (int i = 0; i < 800; i++) begin
            if (m_step == 0 || $urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 39) == 0, op, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode control unit for the 8-bit bus CPU. It sits directly upstream of every bus register and drives their enable (bus-out) and load (bus-in) strobes.
- It holds a T-state step counter and a halt latch.
- Each cycle it decodes the instruction-register opcode, the current step and the ALU flags into one control word.
- Registers sample the control word at the next rising clk.

Parameters:
- STEP_WIDTH, 3: width of the step counter.
- MAX_STEP, 5: number of T-states in the longest instruction. The counter forcibly wraps to 0 after step MAX_STEP-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  4  upper nibble of the instruction register.
- carry_flag  input  1  latched carry from the flags register.
- zero_flag  input  1  latched zero from the flags register.
- ctrl  output  16  control word. Bit layout: 15 hlt, 14 mi, 13 ri, 12 ro, 11 io, 10 ii, 9 ai, 8 ao, 7 eo, 6 su, 5 bi, 4 oi, 3 ce, 2 co, 1 j, 0 fi.
- step  output  STEP_WIDTH  current T-state, for debug/display.
- halted  output  1  high once HLT has executed.

Behaviour:
- Reset: while rst=1, step<=0 and halted<=0 at each rising clk, and ctrl is forced to 0 combinationally so no register loads or drives during reset. Reset mid-instruction aborts the instruction. The first cycle after rst falls is fetch T0.
- ctrl is a combinational decode of (opcode, step, carry_flag, zero_flag, halted, rst). There is zero latency between a step change and its control word.
- An internal 17th microcode bit, rsc (reset step counter), marks the last step of an instruction. At the rising edge: if rsc=1 then step<=0, else if step==MAX_STEP-1 then step<=0, else step<=step+1.
- Fetch, common to all opcodes:
  - T0: co, mi.
  - T1: ro, ii, ce.
- Execute steps, per opcode:
  - NOP 0x0: T2 rsc.
  - LDA 0x1: T2 io, mi. T3 ro, ai, rsc.
  - ADD 0x2: T2 io, mi. T3 ro, bi. T4 eo, ai, fi, rsc.
  - SUB 0x3: as ADD, with su asserted in T4.
  - STA 0x4: T2 io, mi. T3 ao, ri, rsc.
  - LDI 0x5: T2 io, ai, rsc.
  - JMP 0x6: T2 io, j, rsc.
  - JC 0x7: T2 io, j, rsc if carry_flag=1, else rsc only.
  - JZ 0x8: same rule as JC using zero_flag.
  - OUT 0xE: T2 ao, oi, rsc.
  - HLT 0xF: T2 hlt.
  - Undefined opcodes 0x9–0xD: identical to NOP.
- Flags for JC/JZ are sampled combinationally in T2. A flag change in that same cycle takes effect immediately.
- Halt: when ctrl[15]=1 at a rising edge, halted<=1 and step holds. While halted=1, ctrl=0 and step is frozen. Only rst clears halted.
- Bus exclusivity invariant: at most one of ro, io, ao, eo, co is asserted in any cycle. An implementation that violates this is non-conforming.
- su is asserted only alongside eo. j is asserted only alongside io.

Decomposition:
- Shared include file, cpu_defs.vh:
  - opcode localparams (OP_NOP … OP_HLT).
  - control-bit index localparams (CTRL_HLT=15 … CTRL_FI=0).
  - CTRL_WIDTH=16.
  - These are reused by the top level when wiring register enable/load pins.
- One natural sub-module, microcode_rom:
  - Pure combinational lookup from {opcode, step, carry, zero} to 17 bits (ctrl plus rsc).
  - control_sequencer keeps the step counter, halt latch, reset gating and wrap logic.

Test Plan:
- Reset mid-ADD: assert rst at step 3 for 1 cycle -> ctrl=0 during rst. Next cycle step=0, ctrl=0x4004 (mi|co). halted=0.
- LDA 0x1 from reset: ctrl sequence across steps 0..3 is 0x4004, 0x1408, 0x4800, 0x1200. Step then returns to 0; 4 cycles total.
- SUB 0x3: step 4 ctrl=0x02C1 (ai|eo|su|fi), step 5 never reached. Repeat with opcode 0x2 -> step 4 ctrl=0x0281.
- JC 0x7: carry_flag=1 -> step 2 ctrl=0x0802 (io|j). carry_flag=0 -> step 2 ctrl=0x0000. Both return to step 0 next cycle.
- HLT 0xF: step 2 ctrl=0x8000. Next cycle halted=1, ctrl=0, step frozen at 2 for 10 cycles. rst -> halted=0, step=0.
- Opcode sweep 0x0–0xF over all steps and flag combinations: the bus-exclusivity invariant holds and undefined opcodes match NOP. Forcing the wrap path (rsc suppressed) returns step to 0 after step 4.
